hilo_unit: RTL and testbench
============================

# hilo_unit

HI/LO register unit for the MIPS datapath: owns the architectural HI and LO registers, accepts HI/LO writes produced by the ALU (mthi, mtlo, single-cycle results), and runs an iterative 32×32 multiply engine for mult, multu, madd and msub. It sits beside the ALU in EX. Its `Hi_out` and `Lo_out` feed the ALU's `Hi_in` and `Lo_in` (mfhi, mflo), and its `Busy` drives the hazard unit's stall.

## Interface
Parameters:
- `WIDTH`, 32, operand and register width; the engine runs `WIDTH` iterations.

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request a multiply operation; sampled only when idle.
- `MulOp`  in  2  operation: 00 mult (signed), 01 multu, 10 madd (signed), 11 msub (signed).
- `A`, `B`  in  WIDTH  multiply operands (rs, rt).
- `HiLoWrite`  in  1  direct write strobe from the ALU.
- `HiWD`, `LoWD`  in  WIDTH  direct write data.
- `HiWE`, `LoWE`  in  1  per-register enables qualifying `HiLoWrite` (mthi sets HiWE only).
- `Hi_out`, `Lo_out`  out  WIDTH  registered HI and LO values.
- `Busy`  out  1  multiply in progress.
- `Done`  out  1  one-cycle pulse when a multiply result has been committed.

## Operation
- Reset values: HI=0, LO=0, Busy=0, Done=0, state IDLE, iteration count 0.
- States: IDLE → MUL → FIX → IDLE.
- **IDLE**
  - `Start`=1: latch `MulOp`. Latch |A| and |B|; for signed ops, take two's-complement magnitudes. Record the result sign as A[31]^B[31] (signed ops only). Clear the 64-bit product, set count to 0, go to MUL.
  - `Start`=0 and `HiLoWrite`=1: write HI from `HiWD` if `HiWE`; write LO from `LoWD` if `LoWE`.
  - `Start` and `HiLoWrite` in the same cycle: Start wins and the write is discarded.
- **MUL**: radix-2 shift-add, one multiplier bit per cycle, LSB first. Leave after `WIDTH` cycles, going to FIX.
- **FIX** (one cycle):
  - Negate the 64-bit product if the sign flag is set.
  - mult/multu: {HI,LO} ← product.
  - madd: {HI,LO} ← {HI,LO} + product.
  - msub: {HI,LO} ← {HI,LO} − product.
  - All arithmetic is 64-bit modulo 2^64; carries and borrows propagate from LO into HI.
  - Next state IDLE; Done=1 for one cycle.
- While Busy=1:
  - `Start` is ignored.
  - `HiLoWrite` is discarded. The hazard unit must stall mthi, mtlo, mfhi and mflo while `Busy` is high.
- Magnitude of 0x80000000 is 0x80000000, treated as an unsigned 32-bit value; no overflow flag is produced.
- `Reset` asserted in any state aborts the operation:
  - Next cycle: HI=LO=0, IDLE, Busy=0.
  - No Done pulse is produced for the aborted operation.

## Timing
- The accepting edge is edge 0. MUL iterations occur on edges 1..32 and FIX on edge 33.
- `Busy` is high for the 33 cycles after edge 0.
- After edge 33: `Busy`=0, `Done`=1, and the new `Hi_out`/`Lo_out` are visible in the same cycle.
- A new `Start` can be accepted in the cycle `Done` is high.
- A direct write is visible on `Hi_out`/`Lo_out` in the cycle after the strobe. There is no combinational bypass; EX/MEM forwarding handles back-to-back mthi → mfhi.
- `Busy` and `Done` are registered outputs. `Hi_out` and `Lo_out` are driven directly from registers.

## Structure
- Package `hilo_pkg`:
  - MulOp encodings (`MUL_S`, `MUL_U`, `MADD`, `MSUB`).
  - State enum (`IDLE`, `MUL`, `FIX`).
  - Iteration count constant equal to `WIDTH`.
- Sub-module `hilo_mul_core`:
  - Shift-add datapath: multiplicand, multiplier shift register, 64-bit partial product, count.
  - Driven by `load`/`step` from the unit's FSM; reports `last`.
  - Sign fix and accumulate stay in `hilo_unit`.

## Test plan
- **Signed mult:** mult A=0xFFFFFFFD, B=7 → Busy high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB, Done high exactly one cycle.
- **Unsigned mult and minimum magnitude:**
  - multu A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
  - mult A=B=0x80000000 → HI=0x40000000, LO=0.
- **Direct write then accumulate:**
  - HiLoWrite with both enables, HiWD=0x10, LoWD=0x5.
  - madd A=2, B=3 → HI=0x10, LO=0xB.
  - msub A=4, B=3 → HI=0xF, LO=0xFFFFFFFF.
- **Partial writes:** mthi-style write (HiWE=1, LoWE=0) of 0xABCD → HI=0xABCD, LO unchanged; visible one cycle after the strobe.
- **Collisions:**
  - Start pulsed at busy cycle 5 → ignored, result unchanged.
  - HiLoWrite during Busy → discarded.
  - Start and HiLoWrite in the same idle cycle → write dropped, multiply runs.
- **Reset mid-operation:** Reset at busy cycle 10 → next cycle HI=LO=0, Busy=0, and no Done pulse; a following mult 6×7 yields LO=42, HI=0.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared constants and types for the HI/LO register unit.
// Operation encodings follow the MulOp port.
package hilo_pkg;

    localparam int HILO_W = 32;
    localparam int ITERS  = HILO_W;

    localparam logic [1:0] MUL_S = 2'b00;
    localparam logic [1:0] MUL_U = 2'b01;
    localparam logic [1:0] MADD  = 2'b10;
    localparam logic [1:0] MSUB  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/hilo_mul_core.sv
// Radix-2 shift-add multiplier datapath on unsigned magnitudes.
// Sequenced by load/step from hilo_unit; one multiplier bit per step.
import hilo_pkg::*;

module hilo_mul_core #(
    parameter int WIDTH = HILO_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic               last_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            mcand_d  = {{WIDTH{1'b0}}, mcand_i};
            mplier_d = mplier_i;
            prod_d   = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign prod_o = prod_q;
    assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers with direct ALU writes and an
// iterative multiply / multiply-accumulate engine.
import hilo_pkg::*;

module hilo_unit #(
    parameter int WIDTH = HILO_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MulOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiLoWrite,
    input  logic [WIDTH-1:0] HiWD,
    input  logic [WIDTH-1:0] LoWD,
    input  logic             HiWE,
    input  logic             LoWE,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out,
    output logic             Busy,
    output logic             Done
);

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, done_q;

    logic               signed_op, load, step, last;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod, sprod, acc, res;

    assign signed_op = (MulOp != MUL_U);
    assign mag_a = (signed_op && A[WIDTH-1]) ? -A : A;
    assign mag_b = (signed_op && B[WIDTH-1]) ? -B : B;

    hilo_mul_core #(.WIDTH(WIDTH)) u_core (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (mag_a),
        .mplier_i (mag_b),
        .prod_o   (prod),
        .last_o   (last)
    );

    // Sign fix and accumulate, all modulo 2^(2*WIDTH).
    assign sprod = neg_q ? -prod : prod;
    assign acc   = {hi_q, lo_q};

    always_comb begin
        unique case (op_q)
            MADD:    res = acc + sprod;
            MSUB:    res = acc - sprod;
            default: res = sprod;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d    = MulOp;
                    neg_d   = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                    load    = 1'b1;
                    state_d = MUL;
                end else if (HiLoWrite) begin
                    if (HiWE) hi_d = HiWD;
                    if (LoWE) lo_d = LoWD;
                end
            end
            MUL: begin
                step = 1'b1;
                if (last) state_d = FIX;
            end
            FIX: begin
                {hi_d, lo_d} = res;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            op_q    <= MUL_S;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_q == FIX);
        end
    end

    assign Hi_out = hi_q;
    assign Lo_out = lo_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: randomized and directed multiplies,
// direct writes, collisions and mid-operation reset.
module tb_hilo_unit;

    logic        Clk = 1'b0;
    logic        Reset, Start, HiLoWrite, HiWE, LoWE;
    logic [1:0]  MulOp;
    logic [31:0] A, B, HiWD, LoWD;
    logic [31:0] Hi_out, Lo_out;
    logic        Busy, Done;

    hilo_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .MulOp(MulOp),
        .A(A), .B(B), .HiLoWrite(HiLoWrite), .HiWD(HiWD), .LoWD(LoWD),
        .HiWE(HiWE), .LoWE(LoWE), .Hi_out(Hi_out), .Lo_out(Lo_out),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    int pass_cnt = 0;
    int total = 0;
    logic [63:0] model_hl;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: full-precision product, then 64-bit accumulate.
    function automatic logic [63:0] ref_op(input logic [1:0] op,
        input logic [31:0] a, input logic [31:0] b, input logic [63:0] hl);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        if (op == 2'b01) p = {32'b0, a} * {32'b0, b};
        else p = 64'(sa * sb);
        case (op)
            2'b10:   return hl + p;
            2'b11:   return hl - p;
            default: return p;
        endcase
    endfunction

    // Monitor: every Done must match the oldest expected result.
    always @(negedge Clk) begin
        if (Done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                chk("result", {Hi_out, Lo_out}, exp_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        Start = 0; HiLoWrite = 0; HiWE = 0; LoWE = 0;
        MulOp = 0; A = 0; B = 0; HiWD = 0; LoWD = 0;
    endtask

    task automatic wr(input logic hwe, input logic lwe,
                      input logic [31:0] hd, input logic [31:0] ld);
        @(negedge Clk);
        HiLoWrite = 1; HiWE = hwe; LoWE = lwe; HiWD = hd; LoWD = ld;
        if (hwe) model_hl[63:32] = hd;
        if (lwe) model_hl[31:0] = ld;
        @(negedge Clk);
        HiLoWrite = 0; HiWE = 0; LoWE = 0;
        chk("direct_write", {Hi_out, Lo_out}, model_hl);
    endtask

    // inj: 1 = Start at busy cycle 5, 2 = HiLoWrite at busy cycle 8,
    // 3 = HiLoWrite in the accepting cycle. rst_at: reset at busy cycle.
    task automatic mul(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int inj, input int rst_at);
        int n;
        @(negedge Clk);
        Start = 1; MulOp = op; A = a; B = b;
        if (inj == 3) begin
            HiLoWrite = 1; HiWE = 1; LoWE = 1;
            HiWD = 32'h1111; LoWD = 32'h2222;
        end
        if (rst_at == 0) begin
            model_hl = ref_op(op, a, b, model_hl);
            exp_q.push_back(model_hl);
        end
        @(negedge Clk);
        idle_inputs();
        n = 0;
        while (Busy && n < 100) begin
            n++;
            Start = (inj == 1 && n == 5);
            MulOp = 2'b01; A = 32'h5; B = 32'h9;
            HiLoWrite = (inj == 2 && n == 8);
            HiWE = HiLoWrite; LoWE = HiLoWrite;
            HiWD = 32'hDEAD; LoWD = 32'hBEEF;
            Reset = (rst_at != 0 && n == rst_at);
            @(negedge Clk);
            idle_inputs();
            if (Reset) begin
                Reset = 0;
                model_hl = '0;
                chk("reset_abort", {31'b0, Busy, Done, Hi_out, Lo_out}, '0);
                repeat (40) begin
                    @(negedge Clk);
                    if (Done || Busy) break;
                end
                chk("no_done_after_abort", {63'b0, Done | Busy}, 64'd0);
                return;
            end
        end
        chk("busy_cycles", 64'(n), 64'd33);
        chk("done_high", {63'b0, Done}, 64'd1);
        @(negedge Clk);
        chk("done_one_cycle", {63'b0, Done}, 64'd0);
    endtask

    initial begin
        idle_inputs();
        model_hl = '0;
        Reset = 1;
        repeat (2) @(negedge Clk);
        chk("reset_state", {30'b0, Busy, Done, Hi_out, Lo_out}, '0);
        Reset = 0;

        mul(2'b00, 32'hFFFFFFFD, 32'd7, 0, 0);
        chk("smul_const", model_hl, 64'hFFFFFFFF_FFFFFFEB);
        mul(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        chk("umul_const", model_hl, 64'hFFFFFFFE_00000001);
        mul(2'b00, 32'h80000000, 32'h80000000, 0, 0);
        chk("minmag_const", model_hl, 64'h40000000_00000000);

        wr(1, 1, 32'h10, 32'h5);
        mul(2'b10, 32'd2, 32'd3, 0, 0);
        chk("madd_const", model_hl, 64'h10_0000000B);
        mul(2'b11, 32'd4, 32'd3, 0, 0);
        chk("msub_const", model_hl, 64'hF_FFFFFFFF);
        wr(1, 0, 32'hABCD, 32'h9999);

        mul(2'b00, 32'h1234, 32'hFFFF0000, 1, 0);
        mul(2'b01, 32'h77, 32'h88, 2, 0);
        mul(2'b10, 32'hFFFFFFFF, 32'd5, 3, 0);

        mul(2'b00, 32'h12345678, 32'h9ABCDEF0, 0, 10);
        mul(2'b00, 32'd6, 32'd7, 0, 0);
        chk("after_reset_const", model_hl, 64'd42);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                wr(1'($urandom), 1'($urandom), $urandom, $urandom);
            end
            mul(2'($urandom), $urandom, $urandom, 0, 0);
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("final_hilo", {Hi_out, Lo_out}, model_hl);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
